// File: rtl/ntt_radix_ct_arb_if.sv
// Handshake bundle between two NTT requesters, the shared radix
// datapath input mux and the result-valid fan-out.
interface ntt_radix_ct_arb_if;
    logic req0_vld;
    logic req0_last;
    logic req0_rdy;
    logic req1_vld;
    logic req1_last;
    logic req1_rdy;
    logic cred0_ret;
    logic cred1_ret;
    logic dp_vld;
    logic dp_sel;
    logic out0_vld;
    logic out1_vld;
    logic idle;
    logic err;

    modport slave (
        input  req0_vld, req0_last, req1_vld, req1_last,
        input  cred0_ret, cred1_ret,
        output req0_rdy, req1_rdy, dp_vld, dp_sel,
        output out0_vld, out1_vld, idle, err
    );

    modport master (
        output req0_vld, req0_last, req1_vld, req1_last,
        output cred0_ret, cred1_ret,
        input  req0_rdy, req1_rdy, dp_vld, dp_sel,
        input  out0_vld, out1_vld, idle, err
    );
endinterface

// File: rtl/ntt_radix_ct_arb.sv
// Group-atomic round-robin arbiter for a shared pipelined radix
// butterfly, with per-requester output-buffer credits and a tag line.
module ntt_radix_ct_arb #(
    parameter int LAT    = 6,
    parameter int CREDIT = 8
) (
    input  logic              clk,
    input  logic              a_rst_n,
    ntt_radix_ct_arb_if.slave bus
);
    localparam int CNT_W = $clog2(CREDIT + 1);
    localparam int INF_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CMAX  = CNT_W'(CREDIT);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [INF_W-1:0] I_ONE = INF_W'(1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state_q;
    logic             ptr_q;
    logic             err_q;
    logic             err_d;
    logic             idle_q;
    logic [CNT_W-1:0] c0_q, c0_d;
    logic [CNT_W-1:0] c1_q, c1_d;
    logic [LAT-1:0]   tv_q;
    logic [LAT-1:0]   ts_q;
    logic [INF_W-1:0] inf_q, inf_d;

    logic e0, e1;
    logic any, sel;
    logic rdy0, rdy1;
    logic acc0, acc1, acc;
    logic last, outv;
    logic nxt_idle;

    assign e0 = bus.req0_vld & (c0_q != '0);
    assign e1 = bus.req1_vld & (c1_q != '0);

    // Pick the owner of this cycle's datapath slot; a lock pins it.
    always_comb begin
        any = 1'b0;
        sel = 1'b0;
        unique case (state_q)
            LOCK0: any = 1'b1;
            LOCK1: begin
                any = 1'b1;
                sel = 1'b1;
            end
            default: begin
                any = e0 | e1;
                sel = (e0 & e1) ? ptr_q : e1;
            end
        endcase
    end

    assign rdy0 = any & ~sel & (c0_q != '0);
    assign rdy1 = any &  sel & (c1_q != '0);
    assign acc0 = bus.req0_vld & rdy0;
    assign acc1 = bus.req1_vld & rdy1;
    assign acc  = acc0 | acc1;
    assign last = sel ? bus.req1_last : bus.req0_last;
    assign outv = tv_q[LAT-1];

    assign bus.req0_rdy = rdy0;
    assign bus.req1_rdy = rdy1;
    assign bus.dp_vld   = acc;
    assign bus.dp_sel   = sel;
    assign bus.out0_vld = outv & ~ts_q[LAT-1];
    assign bus.out1_vld = outv &  ts_q[LAT-1];
    assign bus.idle     = idle_q;
    assign bus.err      = err_q;

    // Credit bookkeeping; a return into a full counter saturates and flags.
    always_comb begin
        c0_d  = c0_q;
        c1_d  = c1_q;
        err_d = err_q;
        if (acc0 & ~bus.cred0_ret) begin
            c0_d = c0_q - C_ONE;
        end else if (~acc0 & bus.cred0_ret) begin
            if (c0_q == CMAX) err_d = 1'b1;
            else              c0_d  = c0_q + C_ONE;
        end
        if (acc1 & ~bus.cred1_ret) begin
            c1_d = c1_q - C_ONE;
        end else if (~acc1 & bus.cred1_ret) begin
            if (c1_q == CMAX) err_d = 1'b1;
            else              c1_d  = c1_q + C_ONE;
        end
    end

    // Words in flight: issued minus emerged from the tag line.
    always_comb begin
        inf_d = inf_q;
        unique case ({acc, outv})
            2'b10:   inf_d = inf_q + I_ONE;
            2'b01:   inf_d = inf_q - I_ONE;
            default: inf_d = inf_q;
        endcase
    end

    assign nxt_idle = acc ? last : (state_q == IDLE);

    // Lock FSM, round-robin pointer, credits and registered status.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            c0_q    <= CMAX;
            c1_q    <= CMAX;
            err_q   <= 1'b0;
            inf_q   <= '0;
            idle_q  <= 1'b1;
        end else begin
            if (acc) begin
                if (last) begin
                    state_q <= IDLE;
                    ptr_q   <= ~sel;
                end else begin
                    state_q <= sel ? LOCK1 : LOCK0;
                end
            end
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            err_q  <= err_d;
            inf_q  <= inf_d;
            idle_q <= nxt_idle & (inf_d == '0);
        end
    end

    // Ownership tags ride alongside the datapath and never stall.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            tv_q <= '0;
            ts_q <= '0;
        end else begin
            tv_q[0] <= acc;
            ts_q[0] <= sel;
            for (int i = 1; i < LAT; i++) begin
                tv_q[i] <= tv_q[i-1];
                ts_q[i] <= ts_q[i-1];
            end
        end
    end
endmodule
